// File: rtl/uart_tx_sched.sv
// uart_tx_sched: packet-level round-robin scheduler sharing one UART
// transmitter between two byte-stream requesters. Each granted packet is
// prefixed with a channel header byte, and bytes are issued one at a time,
// waiting for tx_done between them.
module uart_tx_sched #(
  parameter logic [7:0] HDR_BASE = 8'hA0,
  parameter int         MAX_PKT  = 16,
  parameter int         TIMEOUT  = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       tx_vld,
  input  logic       tx_done,
  output logic [1:0] grant,
  output logic       busy,
  output logic       pkt_done,
  output logic       err_timeout
);

  localparam int CNT_W = $clog2(MAX_PKT + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    WAIT_HDR,
    SEND_DATA,
    WAIT_DATA
  } state_t;

  state_t           state;
  logic             ch;          // index of the granted channel
  logic             last_grant;  // index of the channel served most recently
  logic             last_q;      // last flag of the byte currently at the UART
  logic [CNT_W-1:0] count;       // payload bytes sent in this packet
  logic [TMO_W-1:0] tmo_cnt;     // idle cycles waiting for a payload byte

  logic       win_ch;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;

  // NOTE: ready is a pure decode of registered state, so it needs no default
  // assignment and cannot form a latch; it also never depends on valid.
  assign s0_ready = (state == SEND_DATA) && grant[0];
  assign s1_ready = (state == SEND_DATA) && grant[1];

  // Round-robin pick: a lone requester wins, a contest goes to the channel
  // that was not served last.
  assign win_ch = (s0_valid && s1_valid) ? ~last_grant : s1_valid;

  assign sel_valid = ch ? s1_valid : s0_valid;
  assign sel_data  = ch ? s1_data  : s0_data;
  assign sel_last  = ch ? s1_last  : s0_last;

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= 1'b0;
      last_grant  <= 1'b1;
      last_q      <= 1'b0;
      count       <= '0;
      tmo_cnt     <= '0;
      tx_data     <= 8'h00;
      tx_vld      <= 1'b0;
      grant       <= 2'b00;
      busy        <= 1'b0;
      pkt_done    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make every pulse last exactly one cycle;
      // a later assignment in the case below overrides them.
      tx_vld      <= 1'b0;
      pkt_done    <= 1'b0;
      err_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            ch    <= win_ch;
            grant <= win_ch ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            count <= '0;
            state <= SEND_HDR;
          end
        end

        SEND_HDR: begin
          tx_data <= HDR_BASE | {7'b0, ch};
          tx_vld  <= 1'b1;
          state   <= WAIT_HDR;
        end

        WAIT_HDR: begin
          if (tx_done) begin
            tmo_cnt <= '0;
            state   <= SEND_DATA;
          end
        end

        SEND_DATA: begin
          if (sel_valid) begin
            tx_data <= sel_data;
            tx_vld  <= 1'b1;
            last_q  <= sel_last;
            count   <= count + CNT_W'(1);
            state   <= WAIT_DATA;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            // The producer stalled too long: abandon the packet, no pkt_done.
            err_timeout <= 1'b1;
            last_grant  <= ch;
            grant       <= 2'b00;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        WAIT_DATA: begin
          if (tx_done) begin
            if (last_q || (count == CNT_W'(MAX_PKT))) begin
              // Normal end or truncation at MAX_PKT; leftovers re-arbitrate.
              pkt_done   <= 1'b1;
              last_grant <= ch;
              grant      <= 2'b00;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              tmo_cnt <= '0;
              state   <= SEND_DATA;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench for uart_tx_sched. Producers and a UART
// model (tx_done 10 cycles after each tx_vld) run as background processes;
// a table of packet scenarios is replayed and the UART byte stream compared,
// followed by hand-written latency, timeout and mid-packet reset sequences.
module tb_uart_tx_sched;

  localparam int MAX_PKT  = 4;
  localparam int TIMEOUT  = 20;
  localparam int UART_LAT = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic       s0_last = 1'b0, s1_last = 1'b0;
  logic       s0_ready, s1_ready;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_done = 1'b0;
  logic [1:0] grant;
  logic       busy, pkt_done, err_timeout;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .HDR_BASE(8'hA0),
    .MAX_PKT (MAX_PKT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s0_data    (s0_data),
    .s0_valid   (s0_valid),
    .s0_last    (s0_last),
    .s0_ready   (s0_ready),
    .s1_data    (s1_data),
    .s1_valid   (s1_valid),
    .s1_last    (s1_last),
    .s1_ready   (s1_ready),
    .tx_data    (tx_data),
    .tx_vld     (tx_vld),
    .tx_done    (tx_done),
    .grant      (grant),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .err_timeout(err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  int pkt_cnt = 0;
  int tmo_seen = 0;
  int ucnt    = 0;
  bit pend0   = 1'b0;
  bit pend1   = 1'b0;

  logic [7:0] uart_log [$];
  logic [7:0] q0_d [$];
  logic [7:0] q1_d [$];
  logic       q0_l [$];
  logic       q1_l [$];

  // One scenario: payload for each channel (byte 0 in the low lane, one
  // last-flag bit per byte) and the expected UART byte stream.
  typedef struct packed {
    logic [3:0]       n0;
    logic [5:0][7:0]  d0;
    logic [5:0]       l0;
    logic [3:0]       n1;
    logic [5:0][7:0]  d1;
    logic [5:0]       l1;
    logic [3:0]       n_exp;
    logic [11:0][7:0] exp_b;
    logic [3:0]       pkts;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] log_at(input int j);
    logic [7:0] v;
    v = 8'hxx;
    if (j < uart_log.size()) v = uart_log[j];
    return v;
  endfunction

  // UART model: one byte in flight, tx_done pulses UART_LAT cycles later.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      ucnt    = 0;
      tx_done = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) tx_done = 1'b1;
      end
      if (tx_vld) begin
        if (ucnt != 0) viol++;
        uart_log.push_back(tx_data);
        ucnt = UART_LAT;
      end
    end
  end

  // Channel 0 producer: presents the queue head, pops it after a handshake.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pend0 = 1'b0;
      s0_valid = 1'b0;
    end else begin
      if (pend0) begin
        q0_d.delete(0);
        q0_l.delete(0);
        pend0 = 1'b0;
      end
      s0_valid = q0_d.size() > 0;
      s0_data  = s0_valid ? q0_d[0] : 8'h00;
      s0_last  = s0_valid ? q0_l[0] : 1'b0;
      if (s0_valid && s0_ready) pend0 = 1'b1;
    end
  end

  // Channel 1 producer.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pend1 = 1'b0;
      s1_valid = 1'b0;
    end else begin
      if (pend1) begin
        q1_d.delete(0);
        q1_l.delete(0);
        pend1 = 1'b0;
      end
      s1_valid = q1_d.size() > 0;
      s1_data  = s1_valid ? q1_d[0] : 8'h00;
      s1_last  = s1_valid ? q1_l[0] : 1'b0;
      if (s1_valid && s1_ready) pend1 = 1'b1;
    end
  end

  // Protocol monitor: counts pulses and tallies rule violations.
  initial begin
    logic       prev_vld;
    logic       prev_busy;
    logic [1:0] prev_grant;
    prev_vld = 1'b0;
    prev_busy = 1'b0;
    prev_grant = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 1'b0;
        prev_busy = 1'b0;
        prev_grant = 2'b00;
      end else begin
        if (pkt_done) pkt_cnt++;
        if (err_timeout) tmo_seen++;
        if (s0_ready && grant != 2'b01) viol++;
        if (s1_ready && grant != 2'b10) viol++;
        if (grant == 2'b11) viol++;
        if ((grant == 2'b00) == busy) viol++;
        if (prev_vld && tx_vld) viol++;
        if (prev_busy && busy && grant != prev_grant) viol++;
        if (pkt_done && err_timeout) viol++;
        prev_vld = tx_vld;
        prev_busy = busy;
        prev_grant = grant;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    q0_d.delete(); q0_l.delete();
    q1_d.delete(); q1_l.delete();
    uart_log.delete();
    pkt_cnt = 0;
    tmo_seen = 0;
    viol = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] d, input logic l);
    q0_d.push_back(d); q0_l.push_back(l);
  endtask

  task automatic push1(input logic [7:0] d, input logic l);
    q1_d.push_back(d); q1_l.push_back(l);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (q0_d.size() == 0 && q1_d.size() == 0 && !pend0 && !pend1 && !busy && ucnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s idle: still busy=%0b after %0d cycles, required idle", tag, busy, budget);
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (uart_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %0d UART bytes after %0d cycles, required %0d", tag, uart_log.size(), budget, n);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs [6];
    int   k;
    int   rdy;

    // Table of packet scenarios (MAX_PKT = 4 in this bench).
    vecs[0] = '0;  // single ch0 packet
    vecs[0].n0 = 3; vecs[0].d0 = 48'h0000_0033_2211; vecs[0].l0 = 6'b000100;
    vecs[0].n_exp = 4; vecs[0].exp_b = 96'h3322_11A0; vecs[0].pkts = 1;

    vecs[1] = '0;  // simultaneous after reset: ch0 first, then ch1
    vecs[1].n0 = 2; vecs[1].d0 = 48'h0000_0000_5544; vecs[1].l0 = 6'b000010;
    vecs[1].n1 = 1; vecs[1].d1 = 48'h0000_0000_0066; vecs[1].l1 = 6'b000001;
    vecs[1].n_exp = 5; vecs[1].exp_b = 96'h66_A155_44A0; vecs[1].pkts = 2;

    vecs[2] = '0;  // fairness with 1-byte packets
    vecs[2].n0 = 2; vecs[2].d0 = 48'h0000_0000_0201; vecs[2].l0 = 6'b000011;
    vecs[2].n1 = 2; vecs[2].d1 = 48'h0000_0000_0403; vecs[2].l1 = 6'b000011;
    vecs[2].n_exp = 8; vecs[2].exp_b = 96'h04A1_02A0_03A1_01A0; vecs[2].pkts = 4;

    vecs[3] = '0;  // ch1 truncation: 6 bytes -> 4 + 2
    vecs[3].n1 = 6; vecs[3].d1 = 48'hB6B5_B4B3_B2B1; vecs[3].l1 = 6'b100000;
    vecs[3].n_exp = 8; vecs[3].exp_b = 96'hB6B5_A1B4_B3B2_B1A1; vecs[3].pkts = 2;

    vecs[4] = '0;  // truncated ch0 remainder loses the contest to ch1
    vecs[4].n0 = 5; vecs[4].d0 = 48'h00C5_C4C3_C2C1; vecs[4].l0 = 6'b010000;
    vecs[4].n1 = 1; vecs[4].d1 = 48'h0000_0000_00D1; vecs[4].l1 = 6'b000001;
    vecs[4].n_exp = 9; vecs[4].exp_b = 96'hC5_A0D1_A1C4_C3C2_C1A0; vecs[4].pkts = 3;

    vecs[5] = '0;  // exactly MAX_PKT bytes with last: one packet only
    vecs[5].n0 = 4; vecs[5].d0 = 48'h0000_E4E3_E2E1; vecs[5].l0 = 6'b001000;
    vecs[5].n_exp = 5; vecs[5].exp_b = 96'hE4_E3E2_E1A0; vecs[5].pkts = 1;

    // Reset values while rst_n is held low.
    #12;
    check("reset tx_data",  32'(tx_data), 32'h00);
    check("reset tx_vld/pulses", {29'b0, tx_vld, pkt_done, err_timeout}, 32'h0);
    check("reset grant/busy",    {29'b0, grant, busy}, 32'h0);
    check("reset ready",         {30'b0, s0_ready, s1_ready}, 32'h0);

    // Valid-to-header latency and first grant.
    do_reset();
    push0(8'h12, 1'b1);
    @(negedge clk); #1;  // producer raises s0_valid here
    check("lat tx_vld before grant", 32'(tx_vld), 32'h0);
    @(negedge clk); #1;  // SEND_HDR
    check("lat tx_vld in SEND_HDR", 32'(tx_vld), 32'h0);
    check("lat grant", {29'b0, grant, busy}, {29'b0, 2'b01, 1'b1});
    @(negedge clk); #1;  // header pulse
    check("lat header tx_vld", 32'(tx_vld), 32'h1);
    check("lat header data", 32'(tx_data), 32'hA0);
    wait_idle(200, "lat");
    check("lat stream", {16'h0, log_at(0), log_at(1)}, 32'h0000_A012);

    // Table-driven packet scenarios.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int j = 0; j < int'(vecs[i].n0); j++) push0(vecs[i].d0[j], vecs[i].l0[j]);
      for (int j = 0; j < int'(vecs[i].n1); j++) push1(vecs[i].d1[j], vecs[i].l1[j]);
      wait_idle(1000, $sformatf("vec%0d", i));
      check($sformatf("vec%0d byte count", i), 32'(uart_log.size()), 32'(vecs[i].n_exp));
      for (int j = 0; j < int'(vecs[i].n_exp); j++)
        check($sformatf("vec%0d byte%0d", i, j), 32'(log_at(j)), 32'(vecs[i].exp_b[j]));
      check($sformatf("vec%0d pkt_done count", i), 32'(pkt_cnt), 32'(vecs[i].pkts));
      check($sformatf("vec%0d err_timeout count", i), 32'(tmo_seen), 32'h0);
      check($sformatf("vec%0d protocol violations", i), 32'(viol), 32'h0);
    end

    // Timeout: one data byte without last, then the producer goes quiet.
    do_reset();
    push0(8'h77, 1'b0);
    wait_log(2, 200, "tmo data byte");
    k = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (tx_done) break;
    end
    // tx_done is consumed at the next edge; TIMEOUT SEND_DATA cycles follow,
    // so the error pulse is seen on the TIMEOUT+1-th sample after tx_done.
    rdy = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      k++;
      if (err_timeout) break;
      if (s0_ready) rdy++;
    end
    check("tmo cycles to err_timeout", 32'(k), 32'(TIMEOUT + 1));
    check("tmo ready cycles", 32'(rdy), 32'(TIMEOUT));
    check("tmo idle at error", {29'b0, grant, busy}, 32'h0);
    @(negedge clk); #1;
    check("tmo single pulse", 32'(err_timeout), 32'h0);
    check("tmo no pkt_done", 32'(pkt_cnt), 32'h0);
    push0(8'h99, 1'b1);
    push1(8'h88, 1'b1);
    wait_idle(500, "tmo follow-up");
    check("tmo err count", 32'(tmo_seen), 32'h1);
    check("tmo next stream", {log_at(2), log_at(3), log_at(4), log_at(5)}, 32'hA188_A099);
    check("tmo violations", 32'(viol), 32'h0);

    // Reset while a data byte is outstanding at the UART.
    do_reset();
    push0(8'h31, 1'b0); push0(8'h32, 1'b0); push0(8'h33, 1'b1);
    push1(8'h41, 1'b1);
    wait_log(2, 200, "rst data byte");
    #2 rst_n = 1'b0;
    #1;
    check("midrst tx_data", 32'(tx_data), 32'h00);
    check("midrst pulses", {29'b0, tx_vld, pkt_done, err_timeout}, 32'h0);
    check("midrst grant/busy", {29'b0, grant, busy}, 32'h0);
    check("midrst ready", {30'b0, s0_ready, s1_ready}, 32'h0);
    do_reset();
    push0(8'h5A, 1'b1);
    push1(8'h5B, 1'b1);
    wait_idle(500, "midrst restart");
    check("midrst priority", {log_at(0), log_at(1), log_at(2), log_at(3)}, 32'hA05A_A15B);
    check("midrst pkt_done count", 32'(pkt_cnt), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Packet-level scheduler that shares the single UART transmitter between two byte-stream requesters.
- Arbitrates per packet, round-robin.
- Prefixes each packet with a channel header byte.
- Issues one byte at a time to the UART transmit interface (tx_data/tx_vld/tx_done) and waits for tx_done before issuing the next.
- Sits between the on-chip producers and uart_top's transmit side.

Parameters:
HDR_BASE, 8'hA0, header byte base; header = HDR_BASE | {7'b0, channel}
MAX_PKT, 16, max payload bytes per grant; range 1..255
TIMEOUT, 5000, max clk cycles waiting for a payload byte before the packet is aborted; >=1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
s0_data  input  8  channel 0 payload byte
s0_valid  input  1  channel 0 byte valid
s0_last  input  1  channel 0 byte is last of packet
s0_ready  output  1  channel 0 byte accepted when valid&ready
s1_data  input  8  channel 1 payload byte
s1_valid  input  1  channel 1 byte valid
s1_last  input  1  channel 1 byte is last of packet
s1_ready  output  1  channel 1 byte accepted when valid&ready
tx_data  output  8  byte to UART transmitter
tx_vld  output  1  one-cycle start pulse to UART transmitter
tx_done  input  1  one-cycle pulse from UART when byte fully sent (stop bit done)
grant  output  2  one-hot owner of UART, 0 when idle
busy  output  1  high whenever state != IDLE
pkt_done  output  1  one-cycle pulse when a packet completes normally or by truncation
err_timeout  output  1  one-cycle pulse when a packet is aborted by timeout

Behaviour:
- Reset values: tx_data=0, tx_vld=0, grant=0, busy=0, pkt_done=0, err_timeout=0, s0_ready=s1_ready=0. Round-robin pointer last_grant=1, so channel 0 wins the first contest. All async, by rst_n.
- FSM states: IDLE, SEND_HDR, WAIT_HDR, SEND_DATA, WAIT_DATA.
- IDLE: a request is sX_valid=1.
  - One requester: grant it.
  - Both requesting: grant the channel != last_grant.
  - On grant: register grant, clear byte count, go to SEND_HDR.
  - Valid-to-header latency: header tx_vld asserts exactly 2 cycles after the cycle valid is first seen in IDLE.
- SEND_HDR: tx_vld=1 for exactly one cycle, tx_data=HDR_BASE|ch; go to WAIT_HDR. No payload is accepted.
- WAIT_HDR: hold tx_data. On tx_done, go to SEND_DATA and clear the timeout counter.
- SEND_DATA:
  - sX_ready=1 for the granted channel only; it is a combinational decode of state and grant. The other channel's ready stays 0.
  - On valid&ready: register tx_data=byte, pulse tx_vld next cycle, latch last, increment count, go to WAIT_DATA.
  - Otherwise the timeout counter increments. On reaching TIMEOUT: pulse err_timeout, set last_grant=ch, go to IDLE; no pkt_done.
- WAIT_DATA: on tx_done:
  - If latched last=1 or count==MAX_PKT: pulse pkt_done, set last_grant=ch, go to IDLE.
  - Otherwise: clear the timeout counter, go to SEND_DATA.
- tx_vld is always a single-cycle registered pulse. At most one byte is outstanding at the UART.
- tx_done outside WAIT_HDR/WAIT_DATA is ignored.
- Truncation: a packet reaching MAX_PKT bytes without last ends with pkt_done. Remaining bytes of that producer form a new packet with a new header, subject to arbitration.
- Widths:
  - count is $clog2(MAX_PKT+1) bits.
  - The timeout counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
- Valid dropping before grant: no commitment is made; IDLE re-evaluates every cycle.
- Reset mid-packet: the FSM returns to IDLE immediately and no pulses are emitted. uart_top shares rst_n, so no stale tx_done arrives.
- grant and busy change only on IDLE entry/exit.

Test Plan:
All scenarios use a UART model that returns tx_done 10 cycles after each tx_vld.
1. Single packet: ch0 sends 8'h11, 8'h22, 8'h33 (last on 8'h33) -> UART sees A0, 11, 22, 33; one pkt_done; grant=2'b01 throughout, then 0; s1_ready stays 0.
2. Simultaneous: both channels valid in the same IDLE cycle after reset -> ch0 packet (header A0) fully sent, then ch1 packet (header A1); no byte interleaving.
3. Fairness: both channels continuously offer 1-byte packets -> header sequence A0, A1, A0, A1 for 4 packets.
4. Truncation: MAX_PKT=4, ch1 streams 6 bytes with last on the 6th -> A1 + 4 bytes + pkt_done, then A1 + 2 bytes + pkt_done.
5. Timeout: TIMEOUT=20, ch0 sends header plus 1 byte without last, then drops valid -> err_timeout pulses exactly 20 cycles into SEND_DATA; FSM idles; a subsequent ch1 request is granted.
6. Reset mid-op: assert rst_n=0 during WAIT_DATA -> all outputs at reset values immediately; after release, ch0 has priority again.
